// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
// Size encodings, FSM states and the byte-mask helper.
package dmem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_t;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        unique case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports and memory pins of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0;
    logic              we0;
    logic [1:0]        size0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;

    logic              req1;
    logic              we1;
    logic [1:0]        size1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;

    logic [DATA_W-1:0] rdata;
    logic              err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, size0, addr0, wdata0,
        input  req1, we1, size1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, done0, gnt1, done1,
        output rdata, err,
        output mem_addr, mem_wdata,
        output mem_write, mem_read
    );

    modport master (
        output req0, we0, size0, addr0, wdata0,
        output req1, we1, size1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, done0, gnt1, done1,
        input  rdata, err,
        input  mem_addr, mem_wdata,
        input  mem_write, mem_read
    );

endinterface

// File: rtl/dmem_lane_merge.sv
// Byte-lane merge for sub-dword stores and
// zero-extended lane extraction for loads.
module dmem_lane_merge
    import dmem_arb_pkg::*;
(
    input  logic [2:0]  lane,
    input  logic [1:0]  size,
    input  logic [63:0] old_dw,
    input  logic [63:0] new_dw,
    output logic [63:0] merged,
    output logic [63:0] load_val
);

    logic [7:0]  bm;
    logic [63:0] sm;
    logic [63:0] wm;
    logic [5:0]  sh;

    always_comb begin
        bm = size_mask(size);
        sm = '0;
        for (int i = 0; i < 8; i++)
            sm[i*8 +: 8] = {8{bm[i]}};
        sh = {lane, 3'b000};
        wm = sm << sh;
        merged = (old_dw & ~wm) |
                 ((new_dw << sh) & wm);
        load_val = (old_dw >> sh) & sm;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter / RMW sequencer for the 64-bit data memory.
// Define DMEM_ARB_RR_EN for round-robin; otherwise port 0 has priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64
) (
    input logic          clk,
    input logic          rst_n,
    dmem_arbiter_if.slave bus
);

    state_t            state;
    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] rdata_q;
    logic              port_q;
    logic              err_q;

    logic              any_req;
    logic              win;
    logic              w_we;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [2:0]        am;
    logic              bad;
    logic              grant;

    logic [DATA_W-1:0] lm_old;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_val;

    assign any_req = bus.req0 | bus.req1;
    assign grant   = (state == IDLE) && any_req;

`ifdef DMEM_ARB_RR_EN
    logic last;

    // On a tie the port not granted last time wins.
    assign win = (bus.req0 && bus.req1) ? ~last : ~bus.req0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (grant)
            last <= win;
    end
`else
    assign win = ~bus.req0;
`endif

    always_comb begin
        w_we    = win ? bus.we1    : bus.we0;
        w_size  = win ? bus.size1  : bus.size0;
        w_addr  = win ? bus.addr1  : bus.addr0;
        w_wdata = win ? bus.wdata1 : bus.wdata0;
        unique case (w_size)
            SZ_B:    am = 3'd0;
            SZ_H:    am = 3'd1;
            SZ_W:    am = 3'd3;
            default: am = 3'd7;
        endcase
        bad = (|(w_addr[2:0] & am)) ||
              (w_addr >= ADDR_W'(DEPTH));
    end

    assign bus.gnt0 = grant && !win;
    assign bus.gnt1 = grant && win;

    assign lm_old = (state == MERGE) ? old_q : bus.mem_rdata;

    dmem_lane_merge u_merge (
        .lane     (addr_q[2:0]),
        .size     (size_q),
        .old_dw   (lm_old),
        .new_dw   (wdata_q),
        .merged   (merged),
        .load_val (load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        we_q    <= w_we;
                        size_q  <= w_size;
                        addr_q  <= w_addr;
                        wdata_q <= w_wdata;
                        port_q  <= win;
                        err_q   <= bad;
                        if (bad) begin
                            rdata_q <= '0;
                            state   <= RESP;
                        end else begin
                            state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_val;
                        state   <= RESP;
                    end else if (size_q == SZ_D) begin
                        state   <= RESP;
                    end else begin
                        old_q   <= bus.mem_rdata;
                        state   <= MERGE;
                    end
                end
                MERGE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic acc;
    logic dw_st;

    // Strobes come straight from state so reset kills them at once.
    assign acc   = (state == ACCESS);
    assign dw_st = we_q && (size_q == SZ_D);

    assign bus.mem_read  = acc && !dw_st;
    assign bus.mem_write = (acc && dw_st) ||
                           (state == MERGE);
    assign bus.mem_addr  = (acc || state == MERGE) ?
                           {addr_q[ADDR_W-1:3], 3'b000} :
                           '0;
    assign bus.mem_wdata = (state == MERGE) ? merged :
                           (acc && dw_st)   ? wdata_q :
                           '0;

    assign bus.done0 = (state == RESP) && !port_q;
    assign bus.done1 = (state == RESP) && port_q;
    assign bus.err   = (state == RESP) && err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// Byte-array memory model; checks latency, data, errors, arbitration, reset.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk;
    logic rst_n;
    logic mem_load;
    int   checks;
    int   errors;
    int   cyc;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .ADDR_W (64),
        .DATA_W (64),
        .DEPTH  (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:63];

    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++)
            bus.mem_rdata[i*8 +: 8] =
                mem[{bus.mem_addr[5:3], 3'(i)}];
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= 8'(i & 31);
        end else if (bus.mem_write) begin
            for (int i = 0; i < 8; i++)
                mem[{bus.mem_addr[5:3], 3'(i)}] <=
                    bus.mem_wdata[i*8 +: 8];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    int          g_cyc, d_cyc, rd_cyc, wr_cyc;
    int          d_cnt, rd_cnt, wr_cnt, both_cnt;
    logic        d_port, d_err;
    logic [63:0] d_rdata, wr_data;
    int          g_seq [$];

    always @(negedge clk) begin
        if (bus.gnt0) begin
            g_cyc = cyc;
            g_seq.push_back(0);
        end
        if (bus.gnt1) begin
            g_cyc = cyc;
            g_seq.push_back(1);
        end
        if (bus.done0 || bus.done1) begin
            d_cyc   = cyc;
            d_cnt   = d_cnt + 1;
            d_port  = bus.done1;
            d_err   = bus.err;
            d_rdata = bus.rdata;
        end
        if (bus.mem_read) begin
            if (rd_cnt == 0) rd_cyc = cyc;
            rd_cnt = rd_cnt + 1;
        end
        if (bus.mem_write) begin
            wr_cyc  = cyc;
            wr_data = bus.mem_wdata;
            wr_cnt  = wr_cnt + 1;
        end
        if (bus.mem_read && bus.mem_write)
            both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h",
                     tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        d_cnt  = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        g_cyc  = -100;
        d_cyc  = -200;
        rd_cyc = -300;
        wr_cyc = -400;
        g_seq.delete();
    endtask

    task automatic drive(input bit p, input bit r,
                         input bit we,
                         input logic [1:0] sz,
                         input logic [63:0] a,
                         input logic [63:0] wd);
        if (p) begin
            bus.req1 = r; bus.we1 = we;
            bus.size1 = sz; bus.addr1 = a;
            bus.wdata1 = wd;
        end else begin
            bus.req0 = r; bus.we0 = we;
            bus.size0 = sz; bus.addr0 = a;
            bus.wdata0 = wd;
        end
    endtask

    task automatic xact(input bit p, input bit we,
                        input logic [1:0] sz,
                        input logic [63:0] a,
                        input logic [63:0] wd);
        bit got;
        @(posedge clk); #1;
        clr_mon();
        drive(p, 1'b1, we, sz, a, wd);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk); #1;
            got = p ? bus.gnt1 : bus.gnt0;
        end
        if (!got) chk("gnt_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, SZ_B, 64'd0, 64'd0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk); #1;
            got = p ? bus.done1 : bus.done0;
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        both_cnt = 0;
        rst_n    = 1'b0;
        mem_load = 1'b1;
        drive(1'b0, 1'b0, 1'b0, SZ_B, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, SZ_B, 64'd0, 64'd0);
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_err",   64'(bus.err), 64'd0);
        chk("rst_wr",    64'(bus.mem_write), 64'd0);
        chk("rst_rd",    64'(bus.mem_read), 64'd0);
        chk("rst_done",
            64'({bus.done1, bus.done0}), 64'd0);
        rst_n    = 1'b1;
        mem_load = 1'b0;

        // Dword load port 0 from 8.
        xact(1'b0, 1'b0, SZ_D, 64'd8, 64'd0);
        chk("ld8_lat",  64'(d_cyc - g_cyc), 64'd2);
        chk("ld8_port", 64'(d_port), 64'd0);
        chk("ld8_data", d_rdata, 64'h0F0E0D0C0B0A0908);
        chk("ld8_err",  64'(d_err), 64'd0);
        chk("ld8_wr",   64'(wr_cnt), 64'd0);

        // Byte store port 1 to 10 (RMW).
        xact(1'b1, 1'b1, SZ_B, 64'd10, 64'hAB);
        chk("sb_lat",   64'(d_cyc - g_cyc), 64'd3);
        chk("sb_port",  64'(d_port), 64'd1);
        chk("sb_rdcyc", 64'(rd_cyc - g_cyc), 64'd1);
        chk("sb_wrcyc", 64'(wr_cyc - g_cyc), 64'd2);
        chk("sb_wdata", wr_data, 64'h0F0E0D0C0BAB0908);
        chk("sb_hold",  d_rdata, 64'h0F0E0D0C0B0A0908);
        xact(1'b0, 1'b0, SZ_B, 64'd10, 64'd0);
        chk("lb10",     d_rdata, 64'hAB);

        // Word load from 36.
        xact(1'b1, 1'b0, SZ_W, 64'd36, 64'd0);
        chk("lw36",     d_rdata, 64'h0000000007060504);

        // Dword store then half load back.
        xact(1'b0, 1'b1, SZ_D, 64'd0,
             64'h1122334455667788);
        chk("sd_lat",   64'(d_cyc - g_cyc), 64'd2);
        chk("sd_wdata", wr_data, 64'h1122334455667788);
        chk("sd_rd",    64'(rd_cnt), 64'd0);
        xact(1'b1, 1'b0, SZ_H, 64'd6, 64'd0);
        chk("lh6",      d_rdata, 64'h1122);

        // Half store into dword 16..23.
        xact(1'b1, 1'b1, SZ_H, 64'd18, 64'hBEEF);
        chk("sh_wdata", wr_data, 64'h17161514BEEF1110);
        xact(1'b0, 1'b0, SZ_W, 64'd16, 64'd0);
        chk("lw16",     d_rdata, 64'h00000000BEEF1110);

        // Error cases.
        xact(1'b0, 1'b1, SZ_H, 64'd3, 64'h55);
        chk("mis_lat",  64'(d_cyc - g_cyc), 64'd1);
        chk("mis_err",  64'(d_err), 64'd1);
        chk("mis_strb", 64'(rd_cnt + wr_cnt), 64'd0);
        chk("mis_rd0",  d_rdata, 64'd0);
        xact(1'b1, 1'b0, SZ_D, 64'd64, 64'd0);
        chk("oor_lat",  64'(d_cyc - g_cyc), 64'd1);
        chk("oor_err",  64'(d_err), 64'd1);
        chk("oor_strb", 64'(rd_cnt + wr_cnt), 64'd0);
        xact(1'b0, 1'b0, SZ_W, 64'd2, 64'd0);
        chk("misw_err", 64'(d_err), 64'd1);
        xact(1'b0, 1'b0, SZ_B, 64'd40, 64'd0);
        chk("ok_err",   64'(d_err), 64'd0);
        chk("lb40",     d_rdata, 64'h8);

        // Reset asserted during MERGE.
        begin
            bit got;
            @(posedge clk); #1;
            clr_mon();
            drive(1'b0, 1'b1, 1'b1, SZ_B, 64'd40, 64'h5A);
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(negedge clk); #1;
                got = bus.gnt0;
            end
            if (!got) chk("rgnt_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 1'b0, SZ_B, 64'd0, 64'd0);
            @(posedge clk); #1;
            chk("mrg_wr",   64'(bus.mem_write), 64'd1);
            rst_n = 1'b0;
            #1;
            chk("rst_wr0",  64'(bus.mem_write), 64'd0);
            chk("rst_st",   64'(dut.state), 64'(IDLE));
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            chk("rst_nodn", 64'(d_cnt), 64'd0);
            chk("rst_mem",  64'(mem[40]), 64'h08);
            chk("rst_rd0",  bus.rdata, 64'd0);
        end

        // Both ports requesting continuously.
        @(posedge clk); #1;
        clr_mon();
        drive(1'b0, 1'b1, 1'b0, SZ_D, 64'd0, 64'd0);
        drive(1'b1, 1'b1, 1'b0, SZ_D, 64'd8, 64'd0);
        repeat (12) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, SZ_B, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, SZ_B, 64'd0, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("arb_cnt", 64'(g_seq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            int e;
`ifdef DMEM_ARB_RR_EN
            e = i % 2;
`else
            e = 0;
`endif
            chk($sformatf("arb_g%0d", i),
                64'(i < g_seq.size() ? g_seq[i] : 9),
                64'(e));
        end
        chk("arb_done", 64'(d_cnt), 64'd4);
        chk("excl_rw",  64'(both_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
